// File: rtl/scope_arb_pkg.sv
// Shared types and helpers for the scope array arbiter.
package scope_arb_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_OWNED
  } state_t;

  // Width of an index into n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit in reqvec searching from last+1 modulo n; returns last if none.
  function automatic int next_rr(input int last, input logic [31:0] reqvec, input int n);
    int idx;
    next_rr = last;
    for (int k = 32; k >= 1; k--) begin
      if (k <= n) begin
        idx = (last + k) % n;
        if (reqvec[idx]) next_rr = idx;
      end
    end
  endfunction

endpackage

// File: rtl/scope_array_store.sv
// DEPTH x WIDTH register array; each entry lives in generate scope entry[k].
module scope_array_store
  import scope_arb_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_mux;

  for (genvar k = 0; k < DEPTH; k++) begin : entry
    logic [WIDTH-1:0] q;
    // Entry register, cleared on reset, written when addressed.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= '0;
      else if (wr_en && (wr_addr == AW'(k))) q <= wr_data;
    end
    assign mem[k] = q;
  end

  // Read select; addresses past DEPTH read as zero.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (rd_addr == AW'(k)) rd_mux = mem[k];
    end
  end

  // Registered read port; holds its last value between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else if (rd_en) rd_data <= rd_mux;
  end

endmodule

// File: rtl/scope_array_arbiter.sv
// Round-robin arbiter with hold limit in front of the shared scope array.
module scope_array_arbiter
  import scope_arb_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int DEPTH    = 3,
  parameter int WIDTH    = 8,
  parameter int AW       = 2,
  parameter int MAX_HOLD = 4,
  localparam int OW      = clog2_min1(NREQ),
  localparam int HW      = clog2_min1(MAX_HOLD)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       we,
  input  logic [NREQ*AW-1:0]    addr,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rvalid,
  output logic                  err,
  output logic [OW-1:0]         owner
);

  state_t            state, state_n;
  logic [OW-1:0]     owner_n, last_q, last_n;
  logic [HW-1:0]     hold_q, hold_n;
  logic [NREQ-1:0]   gnt_n, own_oh, others;
  logic              acc, cur_we, in_range;
  logic [AW-1:0]     cur_addr;
  logic [WIDTH-1:0]  cur_wdata;

  // Access mux: the current owner's request fields.
  always_comb begin
    own_oh         = '0;
    own_oh[owner]  = 1'b1;
    others         = req & ~own_oh;
    cur_addr       = addr[int'(owner)*AW +: AW];
    cur_wdata      = wdata[int'(owner)*WIDTH +: WIDTH];
    cur_we         = we[owner];
    acc            = (state == ST_OWNED) && req[owner];
    in_range       = int'(cur_addr) < DEPTH;
  end

  // Next-state, hold counter and grant decode.
  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last_q;
    hold_n  = hold_q;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          state_n = ST_OWNED;
          owner_n = OW'(next_rr(int'(last_q), 32'(req), NREQ));
          hold_n  = '0;
        end
      end
      ST_OWNED: begin
        if (req[owner]) begin
          if ((hold_q == HW'(MAX_HOLD - 1)) && (|others)) begin
            owner_n = OW'(next_rr(int'(owner), 32'(others), NREQ));
            last_n  = owner;
            hold_n  = '0;
          end else if (hold_q != HW'(MAX_HOLD - 1)) begin
            hold_n = hold_q + 1'b1;
          end
        end else begin
          last_n = owner;
          hold_n = '0;
          if (|others) owner_n = OW'(next_rr(int'(owner), 32'(others), NREQ));
          else state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    gnt_n = '0;
    if (state_n == ST_OWNED) gnt_n[owner_n] = 1'b1;
  end

  // State, grant and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      owner  <= '0;
      last_q <= OW'(NREQ - 1);
      hold_q <= '0;
      gnt    <= '0;
      rvalid <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      owner  <= owner_n;
      last_q <= last_n;
      hold_q <= hold_n;
      gnt    <= gnt_n;
      rvalid <= acc & ~cur_we;
      err    <= acc & ~in_range;
    end
  end

  scope_array_store #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH),
    .AW   (AW)
  ) u_store (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (acc & cur_we & in_range),
    .wr_addr(cur_addr),
    .wr_data(cur_wdata),
    .rd_en  (acc & ~cur_we),
    .rd_addr(cur_addr),
    .rd_data(rdata)
  );

endmodule

// File: tb/tb_scope_array_arbiter.sv
// Self-checking bench for scope_array_arbiter (NREQ=2, DEPTH=3, WIDTH=8).
module tb_scope_array_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we;
  logic [3:0]  addr;
  logic [15:0] wdata;
  logic [1:0]  gnt;
  logic [7:0]  rdata;
  logic        rvalid, err;
  logic [0:0]  owner;

  int chk  = 0;
  int pass = 0;

  typedef struct {
    logic       rd;
    logic [7:0] data;
    logic       er;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mdl [4];

  always #5 clk = ~clk;

  scope_array_arbiter #(
    .NREQ(2), .DEPTH(3), .WIDTH(8), .AW(2), .MAX_HOLD(4)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .err(err), .owner(owner)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push expected response at the access edge, check it one cycle later.
  initial begin
    exp_t       e;
    int         i;
    logic [1:0] a;
    for (int k = 0; k < 4; k++) mdl[k] = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        for (int k = 0; k < 4; k++) mdl[k] = 8'h00;
      end else begin
        chk++;
        if ($onehot0(gnt)) pass++;
        else $display("FAIL gnt_onehot0: got %b required zero or one-hot", gnt);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk++;
          if (rvalid === e.rd && err === e.er && (!e.rd || rdata === e.data)) pass++;
          else $display("FAIL sb_access: got rvalid=%b err=%b rdata=%h required rvalid=%b err=%b rdata=%h",
                        rvalid, err, rdata, e.rd, e.er, e.data);
        end else begin
          chk++;
          if (rvalid === 1'b0 && err === 1'b0) pass++;
          else $display("FAIL sb_spurious: got rvalid=%b err=%b required 0 0", rvalid, err);
        end
        if (|(gnt & req)) begin
          i = gnt[1] ? 1 : 0;
          a = addr[i*2 +: 2];
          if (we[i]) begin
            if (a < 2'd3) mdl[a] = wdata[i*8 +: 8];
            else begin
              e.rd = 1'b0; e.data = 8'h00; e.er = 1'b1;
              sb.push_back(e);
            end
          end else begin
            e.rd   = 1'b1;
            e.data = (a < 2'd3) ? mdl[a] : 8'h00;
            e.er   = (a >= 2'd3);
            sb.push_back(e);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; req = 2'b00; we = 2'b00; addr = 4'h0; wdata = 16'h0000;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    chk++; if (gnt === 2'b00) pass++; else $display("FAIL reset_gnt: got %b required 00", gnt);
    chk++; if (rvalid === 1'b0) pass++; else $display("FAIL reset_rvalid: got %b required 0", rvalid);
    chk++; if (err === 1'b0) pass++; else $display("FAIL reset_err: got %b required 0", err);
    chk++; if (owner === 1'b0) pass++; else $display("FAIL reset_owner: got %b required 0", owner);
    chk++; if (rdata === 8'h00) pass++; else $display("FAIL reset_rdata: got %h required 00", rdata);
    rst = 1'b0;
    step();
    chk++; if (gnt === 2'b00) pass++; else $display("FAIL idle_gnt: got %b required 00", gnt);
  endtask

  task automatic test_write_read();
    req = 2'b01; we = 2'b01; addr = 4'b0001; wdata = 16'h00A5;
    step();
    chk++; if (gnt === 2'b01) pass++; else $display("FAIL wr_grant_latency: got %b required 01", gnt);
    step();
    we = 2'b00;
    step();
    chk++; if (rvalid === 1'b1 && rdata === 8'hA5) pass++;
    else $display("FAIL rd_after_wr: got rvalid=%b rdata=%h required 1 a5", rvalid, rdata);
    req = 2'b00;
    step();
    chk++; if (gnt === 2'b00) pass++; else $display("FAIL wr_release: got %b required 00", gnt);
  endtask

  task automatic test_rotation();
    logic [1:0] exp_g;
    do_reset();
    req = 2'b11; we = 2'b00; addr = 4'b0000;
    for (int k = 0; k < 12; k++) begin
      step();
      exp_g = (k < 4) ? 2'b01 : ((k < 8) ? 2'b10 : 2'b01);
      chk++; if (gnt === exp_g) pass++;
      else $display("FAIL rotate_gnt[%0d]: got %b required %b", k, gnt, exp_g);
      chk++; if (rvalid === (k > 0)) pass++;
      else $display("FAIL rotate_rvalid[%0d]: got %b required %b", k, rvalid, (k > 0));
    end
    req = 2'b00;
    step();
    chk++; if (gnt === 2'b00) pass++; else $display("FAIL rotate_release: got %b required 00", gnt);
  endtask

  task automatic test_hold();
    req = 2'b10; we = 2'b00; addr = 4'b1000;
    for (int k = 0; k < 10; k++) begin
      step();
      chk++; if (gnt === 2'b10 && owner === 1'b1) pass++;
      else $display("FAIL hold_gnt[%0d]: got gnt=%b owner=%b required 10 1", k, gnt, owner);
    end
    req = 2'b00;
    step();
    chk++; if (gnt === 2'b00) pass++; else $display("FAIL hold_release: got %b required 00", gnt);
  endtask

  task automatic test_out_of_range();
    req = 2'b01; we = 2'b01; addr = 4'b0010; wdata = 16'h005A;
    step();
    step();
    addr = 4'b0011; wdata = 16'h00FF;
    step();
    chk++; if (err === 1'b1 && rvalid === 1'b0) pass++;
    else $display("FAIL oor_write: got err=%b rvalid=%b required 1 0", err, rvalid);
    we = 2'b00;
    step();
    chk++; if (err === 1'b1 && rvalid === 1'b1 && rdata === 8'h00) pass++;
    else $display("FAIL oor_read: got err=%b rvalid=%b rdata=%h required 1 1 00", err, rvalid, rdata);
    addr = 4'b0000;
    step();
    chk++; if (err === 1'b0 && rvalid === 1'b1) pass++;
    else $display("FAIL oor_err_pulse: got err=%b rvalid=%b required 0 1", err, rvalid);
    addr = 4'b0001;
    step();
    addr = 4'b0010;
    step();
    chk++; if (rdata === 8'h5A) pass++; else $display("FAIL oor_entry2: got %h required 5a", rdata);
    req = 2'b00;
    step();
  endtask

  task automatic test_reset_mid();
    req = 2'b01; we = 2'b01; addr = 4'b0010; wdata = 16'h003C;
    step();
    step();
    we = 2'b00;
    step();
    chk++; if (rvalid === 1'b1 && rdata === 8'h3C) pass++;
    else $display("FAIL mid_pre_read: got rvalid=%b rdata=%h required 1 3c", rvalid, rdata);
    rst = 1'b1;
    #1;
    chk++; if (gnt === 2'b00 && rvalid === 1'b0 && err === 1'b0) pass++;
    else $display("FAIL mid_reset_async: got gnt=%b rvalid=%b err=%b required 00 0 0", gnt, rvalid, err);
    step();
    rst = 1'b0;
    step();
    chk++; if (gnt === 2'b01 && rvalid === 1'b0) pass++;
    else $display("FAIL mid_regrant: got gnt=%b rvalid=%b required 01 0", gnt, rvalid);
    step();
    chk++; if (rvalid === 1'b1 && rdata === 8'h00) pass++;
    else $display("FAIL mid_cleared: got rvalid=%b rdata=%h required 1 00", rvalid, rdata);
    req = 2'b00;
    step();
  endtask

  task automatic test_handoff();
    do_reset();
    req = 2'b01;
    step();
    chk++; if (gnt === 2'b01) pass++; else $display("FAIL ho_first: got %b required 01", gnt);
    req = 2'b11;
    step();
    chk++; if (gnt === 2'b01) pass++; else $display("FAIL ho_keep: got %b required 01", gnt);
    req = 2'b10;
    step();
    chk++; if (gnt === 2'b10 && owner === 1'b1) pass++;
    else $display("FAIL ho_switch: got gnt=%b owner=%b required 10 1", gnt, owner);
    step();
    chk++; if (gnt === 2'b10) pass++; else $display("FAIL ho_new_owner: got %b required 10", gnt);
    req = 2'b00;
    step();
    chk++; if (gnt === 2'b00) pass++; else $display("FAIL ho_idle: got %b required 00", gnt);
    step();
    chk++; if (gnt === 2'b00 && rvalid === 1'b0) pass++;
    else $display("FAIL ho_idle_quiet: got gnt=%b rvalid=%b required 00 0", gnt, rvalid);
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; we = 2'b00; addr = 4'h0; wdata = 16'h0000;
    test_reset();
    test_write_read();
    test_rotation();
    test_hold();
    test_out_of_range();
    test_reset_mid();
    test_handoff();
    step();
    chk++; if (sb.size() == 0) pass++;
    else $display("FAIL sb_drain: got %0d pending required 0", sb.size());
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
